fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised operand-forwarding and hazard controller for the 5-stage core.
//  Holds shadow tag pipeline registers (EX, MEM, WB) for NSRC source operands,
//  produces per-operand forward selects and forwarded data for the EX stage,
//  and raises stall_o on load-use hazards and multi-cycle (MC) EX operations.
//  Sits beside the ID/EX pipeline register and feeds the ALU operand inputs.
// PARAMETERS
//  XLEN    32  datapath width
//  NSRC    2   source operands per instruction (2 or 3)
//  REG_AW  5   register index width; index 0 is hard-wired zero
//  MC_LAT  4   EX occupancy of an MC op in cycles (>=1; 1 = no extra stall)
// PORTS
//  clk         in   1            clock, rising edge
//  rst_n       in   1            async active-low reset
//  id_valid_i  in   1            valid instruction in ID
//  id_rs_i     in   NSRC*REG_AW  ID source indices, operand k at [k*REG_AW +: REG_AW]
//  id_rd_i     in   REG_AW       ID destination index
//  id_we_i     in   1            ID instruction writes rd
//  id_load_i   in   1            ID instruction is a load
//  id_mc_i     in   1            ID instruction is multi-cycle
//  rf_rdata_i  in   NSRC*XLEN    register-file read data for ID sources
//  ex_res_i    in   XLEN         result held in EX/MEM (ALU result)
//  wb_res_i    in   XLEN         result held in MEM/WB (write-back data)
//  flush_i     in   1            squash instruction in ID (branch/jump taken)
//  fwd_sel_o   out  NSRC*2       per operand: 00 regfile, 01 WB, 10 MEM
//  op_data_o   out  NSRC*XLEN    forwarded operand values for EX instruction
//  stall_o     out  1            hold PC and IF/ID this cycle
//  mc_busy_o   out  1            MC op occupying EX
// BEHAVIOUR
//  Reset: all stage valid bits 0, stored tags/data 0, MC counter 0; so
//   fwd_sel_o=0, op_data_o=0, stall_o=0, mc_busy_o=0.
//  Stage state: EX{v,rs[],rd,we,load,mc,data[]}, MEM{v,rd,we,load}, WB{v,rd,we}.
//  Forward select (comb, per operand k, EX.v=1 and EX.rs[k]!=0):
//   MEM.v&MEM.we&!MEM.load&MEM.rd==rs[k] -> 10 (ex_res_i); else
//   WB.v&WB.we&WB.rd==rs[k] -> 01 (wb_res_i); else 00 (EX.data[k]).
//   MEM has priority over WB. rs[k]==0 or EX.v=0 -> 00.
//  ID capture bypass: when ID enters EX, data[k] = wb_res_i if WB.v&WB.we&
//   WB.rd==id_rs[k]!=0, else rf_rdata_i[k] (covers same-cycle RF write).
//  Load-use (comb): lu = id_valid_i & EX.v & EX.we & EX.load & EX.rd!=0 &
//   EX.rd matches any id_rs[k]. Costs exactly 1 stall cycle.
//  MC counter: loads MC_LAT-1 when an MC instruction enters EX; decrements
//   each cycle while nonzero; mc_busy_o = (cnt!=0).
//  stall_o = lu | mc_busy_o.
//  Per-cycle update, priority top-down:
//   flush_i: EX<=bubble, MEM<=EX, WB<=MEM, cnt<=0 (flush aborts MC op;
//    overrides lu and MC stall).
//   mc_busy: EX held, MEM<=bubble, WB<=MEM, cnt-1.
//   lu: EX<=bubble, MEM<=EX, WB<=MEM (ID held externally by stall_o).
//   normal: EX<=ID if id_valid_i else bubble, MEM<=EX, WB<=MEM.
//  Load leaving MEM reaches WB; after the 1-cycle lu bubble the dependant
//   takes 01 from wb_res_i. A load in MEM is never a forward source.
//  Async reset mid-MC op: counter and all valid bits clear immediately.
// TESTING
//  add x5 then dependent add rs1=x5 next cycle, ex_res_i=0x11 -> sel[0]=10,
//   op_data[0]=0x11, stall_o=0.
//  x5 written two instrs earlier, wb_res_i=0x22 -> sel=01, op_data=0x22; x5 in
//   MEM and WB both -> MEM wins (10).
//  lw x7 then add rs2=x7 -> stall_o=1 exactly one cycle, then sel[1]=01 with
//   wb_res_i value; rs=x0 with rd=x0 producer -> sel=00, no stall.
//  MC op with MC_LAT=4 -> mc_busy_o/stall_o high 3 cycles, MEM gets bubbles,
//   next instr enters EX on cycle 4.
//  flush_i during lu and during MC busy -> stall_o drops next cycle, EX bubble,
//   cnt=0; rst_n low mid-op -> all outputs 0 asynchronously.
//  NSRC=3, XLEN=64 build: third operand forwards from MEM/WB same as above.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard control for the 5-stage core: shadows the EX/MEM/WB
// tags, selects forwarded EX operands and stalls on load-use and multi-cycle EX ops.
module fwd_hazard_unit #(
    parameter int XLEN   = 32,
    parameter int NSRC   = 2,
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [NSRC*REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0]      id_rd_i,
    input  logic                   id_we_i,
    input  logic                   id_load_i,
    input  logic                   id_mc_i,
    input  logic [NSRC*XLEN-1:0]   rf_rdata_i,
    input  logic [XLEN-1:0]        ex_res_i,
    input  logic [XLEN-1:0]        wb_res_i,
    input  logic                   flush_i,
    output logic [NSRC*2-1:0]      fwd_sel_o,
    output logic [NSRC*XLEN-1:0]   op_data_o,
    output logic                   stall_o,
    output logic                   mc_busy_o
);

    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    logic                   ex_v, ex_we, ex_load;
    logic [REG_AW-1:0]      ex_rd;
    logic [NSRC*REG_AW-1:0] ex_rs;
    logic [NSRC*XLEN-1:0]   ex_data;
    logic                   mem_v, mem_we, mem_load;
    logic [REG_AW-1:0]      mem_rd;
    logic                   wb_v, wb_we;
    logic [REG_AW-1:0]      wb_rd;
    logic [CW-1:0]          cnt;

    logic                   lu;
    logic                   mc_busy;
    logic [NSRC*XLEN-1:0]   id_data;

    assign mc_busy   = (cnt != '0);
    assign mc_busy_o = mc_busy;
    assign stall_o   = lu | mc_busy;

    // EX operand select: a load sitting in MEM has no data yet, so it is skipped
    always_comb begin
        fwd_sel_o = '0;
        op_data_o = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (ex_v && ex_rs[k*REG_AW +: REG_AW] != '0 && mem_v && mem_we && !mem_load &&
                mem_rd == ex_rs[k*REG_AW +: REG_AW]) begin
                fwd_sel_o[k*2 +: 2]    = 2'b10;
                op_data_o[k*XLEN +: XLEN] = ex_res_i;
            end else if (ex_v && ex_rs[k*REG_AW +: REG_AW] != '0 && wb_v && wb_we &&
                         wb_rd == ex_rs[k*REG_AW +: REG_AW]) begin
                fwd_sel_o[k*2 +: 2]    = 2'b01;
                op_data_o[k*XLEN +: XLEN] = wb_res_i;
            end else begin
                op_data_o[k*XLEN +: XLEN] = ex_data[k*XLEN +: XLEN];
            end
        end
    end

    // The register file is written this same cycle by WB, so its read port is still stale
    always_comb begin
        id_data = rf_rdata_i;
        for (int k = 0; k < NSRC; k++) begin
            if (wb_v && wb_we && id_rs_i[k*REG_AW +: REG_AW] != '0 &&
                wb_rd == id_rs_i[k*REG_AW +: REG_AW])
                id_data[k*XLEN +: XLEN] = wb_res_i;
        end
    end

    always_comb begin
        lu = 1'b0;
        if (id_valid_i && ex_v && ex_we && ex_load && ex_rd != '0) begin
            for (int k = 0; k < NSRC; k++) begin
                if (id_rs_i[k*REG_AW +: REG_AW] == ex_rd)
                    lu = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v     <= 1'b0;
            ex_we    <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= '0;
            ex_rs    <= '0;
            ex_data  <= '0;
            mem_v    <= 1'b0;
            mem_we   <= 1'b0;
            mem_load <= 1'b0;
            mem_rd   <= '0;
            wb_v     <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            cnt      <= '0;
        end else begin
            // MEM -> WB advances in every case
            wb_v  <= mem_v;
            wb_we <= mem_we;
            wb_rd <= mem_rd;
            if (flush_i) begin
                ex_v     <= 1'b0;
                mem_v    <= ex_v;
                mem_we   <= ex_we;
                mem_load <= ex_load;
                mem_rd   <= ex_rd;
                cnt      <= '0;
            end else if (mc_busy) begin
                mem_v <= 1'b0;
                cnt   <= cnt - CW'(1);
            end else begin
                mem_v    <= ex_v;
                mem_we   <= ex_we;
                mem_load <= ex_load;
                mem_rd   <= ex_rd;
                if (lu) begin
                    ex_v <= 1'b0;
                end else begin
                    ex_v <= id_valid_i;
                    if (id_valid_i) begin
                        ex_rs   <= id_rs_i;
                        ex_rd   <= id_rd_i;
                        ex_we   <= id_we_i;
                        ex_load <= id_load_i;
                        ex_data <= id_data;
                        if (id_mc_i)
                            cnt <= CW'(MC_LAT - 1);
                    end
                end
            end
        end
    end

endmodule
